// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: glyph table, segment bit positions and polarity helper shared by the display driver.
package seven_seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [6:0] SEG_ALL = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) |
                                        (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));

    // Active-high glyphs for 0..F, segment a in bit 0.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] apply_pol(input logic [7:0] v, input logic inv);
        return inv ? ~v : v;
    endfunction

endpackage

// File: rtl/hex_glyph.sv
// hex_glyph: combinational hex nibble to active-high seven-segment glyph.
module hex_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = GLYPHS[nibble] & SEG_ALL;

endmodule

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed seven-segment driver with frame-synchronous loads,
// anti-ghosting blank window and optional leading-zero suppression.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 50000,
    parameter int BLANK          = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic                  enable,
    output logic                  pending,
    output logic                  frame_done,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an
);

    localparam int              PW     = $clog2(DIV);
    localparam int              IW     = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]   PMAX   = PW'(DIV - 1);
    localparam logic [PW-1:0]   PBLANK = PW'(BLANK);
    localparam logic [IW-1:0]   IMAX   = IW'(DIGITS - 1);
    localparam logic            SEG_INV = SEG_ACTIVE_LOW != 0;
    localparam logic            AN_INV  = AN_ACTIVE_LOW != 0;
    localparam logic [7:0]      SEG_OFF = apply_pol(8'h00, SEG_INV);

    logic [PW-1:0]          psc;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    shadow_val, disp_val;
    logic [DIGITS-1:0]      shadow_dp, disp_dp;
    logic [DIGITS-1:0]      lead_zero, an_sel, an_next;
    logic                   slot_end, boundary, cur_dp, cur_blank;
    logic [3:0]             nib;
    logic [6:0]             glyph;
    logic [7:0]             seg_next;

    assign slot_end = psc == PMAX;
    assign boundary = slot_end && idx == IMAX;

    // lead_zero[k]: nibble k and every nibble above it are zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[DIGITS-1] = disp_val[4*DIGITS-1 -: 4] == 4'h0;
        for (int k = DIGITS - 2; k >= 0; k--)
            lead_zero[k] = lead_zero[k+1] && disp_val[4*k +: 4] == 4'h0;
    end

    always_comb begin
        nib = 4'h0;
        cur_dp = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                nib = disp_val[4*k +: 4];
                cur_dp = disp_dp[k];
                cur_blank = lz_blank && lead_zero[k] && k != 0;
            end
        end
    end

    hex_glyph u_glyph (
        .nibble (nib),
        .glyph  (glyph)
    );

    assign seg_next = apply_pol({cur_dp, cur_blank ? 7'h00 : glyph}, SEG_INV);
    assign an_sel   = (enable && psc >= PBLANK) ? DIGITS'(1) << idx : '0;
    assign an_next  = an_sel ^ {DIGITS{AN_INV}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_OFF[6:0];
            dp_out     <= SEG_OFF[7];
            an         <= {DIGITS{AN_INV}};
        end else begin
            psc <= slot_end ? '0 : psc + 1'b1;
            if (slot_end)
                idx <= idx == IMAX ? '0 : idx + 1'b1;
            frame_done <= boundary;
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp;
            end
            // A load landing on the boundary bypasses the shadow so nothing is left pending.
            if (boundary && load) begin
                disp_val <= value;
                disp_dp  <= dp;
            end else if (boundary && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
            end
            pending <= boundary ? 1'b0 : (pending || load);
            seg     <= seg_next[6:0];
            dp_out  <= seg_next[7];
            an      <= an_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench; stimulus queues expected frames, monitor checks them on frame_done.
module tb_seven_seg_scan;

    typedef struct packed {
        logic [27:0] segs;
        logic [3:0]  dps;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] value = '0, value2 = 16'h0008;
    logic [3:0]  dp = '0, dp2 = '0;
    logic        load = 1'b0, load2 = 1'b0, lz_blank = 1'b0, lz2 = 1'b0, enable = 1'b1, enable2 = 1'b1;
    logic        pending, frame_done, dp_out, pending2, frame_done2, dp_out2;
    logic [6:0]  seg, seg2;
    logic [3:0]  an, an2;

    exp_t q[$];
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(.DIGITS(4), .DIV(4), .BLANK(1)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load), .lz_blank(lz_blank),
        .enable(enable), .pending(pending), .frame_done(frame_done), .seg(seg),
        .dp_out(dp_out), .an(an)
    );

    seven_seg_scan #(.DIGITS(4), .DIV(4), .BLANK(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(0)) dut_pol (
        .clk(clk), .rst(rst), .value(value2), .dp(dp2), .load(load2), .lz_blank(lz2),
        .enable(enable2), .pending(pending2), .frame_done(frame_done2), .seg(seg2),
        .dp_out(dp_out2), .an(an2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t mk(input logic [6:0] s0, s1, s2, s3, input logic [3:0] d);
        exp_t e;
        e.segs = {s3, s2, s1, s0};
        e.dps = d;
        return e;
    endfunction

    task automatic wait_frame(input int start, output int cyc);
        cyc = start;
        do begin
            @(negedge clk);
            cyc++;
        end while (!frame_done && cyc < 64);
        if (!frame_done) check("frame_done_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor: frame_done marks slot 0 of a new frame; each digit owns 4 cycles, first one blanked.
    initial begin : monitor
        exp_t e;
        logic [3:0] exp_an;
        forever begin
            @(negedge clk);
            if (frame_done && q.size() > 0) begin
                e = q.pop_front();
                for (int d = 0; d < 4; d++) begin
                    @(negedge clk);
                    check($sformatf("seg_d%0d", d), seg, e.segs[d*7 +: 7]);
                    check($sformatf("dp_d%0d", d), dp_out, e.dps[d]);
                    check($sformatf("an_blank_d%0d", d), an, 4'hF);
                    @(negedge clk);
                    exp_an = ~(4'b0001 << d);
                    check($sformatf("an_sel_d%0d", d), an, exp_an);
                    check($sformatf("seg_hold_d%0d", d), seg, e.segs[d*7 +: 7]);
                    if (d < 3) repeat (2) @(negedge clk);
                end
            end
        end
    end

    initial begin : stimulus
        int c;
        q.push_back(mk(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0));
        repeat (2) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h00);
        check("rst_dp_out", dp_out, 1'b0);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        wait_frame(1, c);
        check("first_frame_period", c, 16);
        check("pol_frame_done", frame_done2, 1'b1);
        check("pol_pending", pending2, 1'b0);
        // Inverted-polarity instance shows 8 on digit 0.
        @(negedge clk);
        check("pol_an_blank", an2, 4'h0);
        check("pol_seg_d0", seg2, 7'h00);
        @(negedge clk);
        check("pol_an_d0", an2, 4'b0001);
        check("pol_seg_d0_lit", seg2, 7'h00);
        check("pol_dp_off", dp_out2, 1'b1);
        repeat (4) @(negedge clk);
        check("pol_an_d1", an2, 4'b0010);
        check("pol_seg_d1", seg2, 7'h40);
        @(negedge clk);
        do_load(16'h12AF, 4'h0);
        check("basic_pending", pending, 1'b1);
        q.push_back(mk(7'h71, 7'h77, 7'h5B, 7'h06, 4'h0));
        wait_frame(8, c);
        check("basic_period", c, 16);
        check("basic_pending_clr", pending, 1'b0);
        // Two loads within one frame: only the last may appear.
        repeat (2) @(negedge clk);
        do_load(16'h0000, 4'h0);
        check("tear_pending1", pending, 1'b1);
        repeat (2) @(negedge clk);
        do_load(16'h5555, 4'h0);
        check("tear_pending2", pending, 1'b1);
        q.push_back(mk(7'h6D, 7'h6D, 7'h6D, 7'h6D, 4'h0));
        repeat (9) @(negedge clk);
        check("tear_pending_boundary", pending, 1'b1);
        wait_frame(15, c);
        check("tear_period", c, 16);
        check("tear_pending_clr", pending, 1'b0);
        // Load exactly in the boundary cycle, with leading-zero blanking.
        repeat (15) @(negedge clk);
        check("bnd_pending_before", pending, 1'b0);
        lz_blank = 1'b1;
        q.push_back(mk(7'h3F, 7'h07, 7'h00, 7'h00, 4'b1000));
        do_load(16'h0070, 4'b1000);
        check("bnd_frame_done", frame_done, 1'b1);
        check("bnd_pending", pending, 1'b0);
        repeat (2) @(negedge clk);
        do_load(16'h0000, 4'h0);
        q.push_back(mk(7'h3F, 7'h00, 7'h00, 7'h00, 4'h0));
        wait_frame(3, c);
        check("lz_period", c, 16);
        wait_frame(0, c);
        check("idle_period", c, 16);
        // Anodes off while counters keep running.
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("en_off_an", an, 4'hF);
        end
        enable = 1'b1;
        wait_frame(8, c);
        check("en_period", c, 16);
        // Asynchronous reset mid-scan.
        repeat (2) @(negedge clk);
        do_load(16'h1234, 4'h0);
        @(negedge clk);
        check("pre_rst_seg", seg, 7'h3F);
        check("pre_rst_an", an, 4'b1110);
        check("pre_rst_pending", pending, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_an", an, 4'hF);
        check("arst_seg", seg, 7'h00);
        check("arst_dp_out", dp_out, 1'b0);
        check("arst_pending", pending, 1'b0);
        check("arst_frame_done", frame_done, 1'b0);
        check("arst_pol_an", an2, 4'h0);
        check("arst_pol_seg", seg2, 7'h7F);
        check("arst_pol_dp", dp_out2, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_frame(0, c);
        check("post_rst_period", c, 16);
        check("post_rst_pending", pending, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
